pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised next-generation fetch program counter for the RISC-V core.
- Generalises the single-mode PC+4/branch counter to four next-PC modes: sequential, PC-relative branch, register-indirect jump (JALR) and trap vector.
- Adds fetch stall, a configurable reset vector, misaligned-target trapping and a small return-address stack (RAS) whose top entry feeds a return predictor.
- Sits between the control unit/ALU and instruction memory.

Parameters:
- PC_WIDTH, 32, width of PC and all address operands.
- RESET_VECTOR, 0, PC value loaded on reset.
- PC_INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-low.
- stall  in  1  1 = hold PC and ignore RAS operations this cycle.
- pc_src  in  2  next-PC select: 00 sequential, 01 branch, 10 jalr, 11 trap.
- imm_op  in  PC_WIDTH  sign-extended immediate offset.
- rs1_val  in  PC_WIDTH  base register value for jalr.
- trap_vec  in  PC_WIDTH  trap handler address.
- ras_push  in  1  push pc_plus onto RAS (call).
- ras_pop  in  1  pop RAS (return).
- pc  out  PC_WIDTH  current fetch address (registered).
- pc_plus  out  PC_WIDTH  pc + PC_INC (combinational).
- misalign  out  1  registered one-cycle pulse: redirect target was misaligned.
- ras_top  out  PC_WIDTH  top RAS entry; 0 when empty.
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset (rst low, asynchronous): pc=RESET_VECTOR, misalign=0, RAS count=0, pointer=0. Entry contents are don't-care but ras_top reads 0. Reset mid-operation discards any pending redirect or RAS operation.
- Target computation: all sums are modulo 2^PC_WIDTH; overflow wraps silently.
  - seq = pc + PC_INC.
  - br = pc + imm_op.
  - jr = (rs1_val + imm_op) with bit0 forced to 0.
  - trap = trap_vec, used unchanged.
- Misalignment:
  - Applies only to pc_src 01 or 10.
  - A target is misaligned when bit1 of the computed target is 1 (bit0 of br also counts).
  - On a misaligned target, next pc = trap_vec and misalign=1 for exactly the following cycle.
  - Otherwise misalign=0.
- Update rules:
  - stall=1: pc, misalign and RAS all hold. Next-PC inputs are ignored.
  - stall=0: pc loads the selected target every rising edge, with one-cycle latency from pc_src to pc.
- RAS, applied only when stall=0, on the same edge as the pc update:
  - push only: write pc_plus (sampled before the edge) at the top. Count saturates at RAS_DEPTH. Pushing when full overwrites the oldest entry as a circular buffer.
  - pop only: count decrements. Pop when empty is ignored with no underflow; count stays 0.
  - push and pop together: top entry is replaced by pc_plus; count unchanged. When empty, this behaves as push only.
- ras_top, ras_empty and ras_full are combinational from RAS state and valid the cycle after the operation.
- No internal FSM beyond the registers above. Each cycle is independent apart from the misalign pulse.

Test Plan:
- Reset: rst=0 with RESET_VECTOR=0x100 -> pc=0x100, ras_empty=1, misalign=0. Then release rst with pc_src=00 for 3 cycles -> pc 0x104, 0x108, 0x10C.
- Branch/jalr: at pc=0x200, pc_src=01, imm_op=0xFFFFFFF0 -> pc=0x1F0. Then pc_src=10, rs1_val=0x301, imm_op=0 -> pc=0x300, misalign=0.
- Misaligned redirect: pc_src=01, imm_op=0x6 at pc=0x200 -> pc=trap_vec (0x80), misalign=1 for one cycle, then 0.
- Stall: stall=1 for 4 cycles with pc_src=01 and ras_push=1 -> pc unchanged and RAS count unchanged. Release stall -> redirect occurs on the next edge.
- RAS overflow/underflow, RAS_DEPTH=4:
  - 5 pushes at pc 0x10, 0x14, 0x18, 0x1C, 0x20 -> ras_full=1, ras_top=0x24.
  - 4 pops -> ras_top sequence 0x20, 0x1C, 0x18, then empty with ras_top=0.
  - 5th pop -> ignored, ras_empty stays 1.
- Simultaneous push/pop and wrap: with 2 entries, push+pop at pc=0x40 -> count stays 2, ras_top=0x44. Separately, pc=0xFFFFFFFC with pc_src=00 -> pc=0x0.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch program counter: four next-PC modes, stall, misaligned-target trapping
// and a small circular return-address stack.
module pc_unit #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned          PC_INC       = 4,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic [1:0]          pc_src,
    input  logic [PC_WIDTH-1:0] imm_op,
    input  logic [PC_WIDTH-1:0] rs1_val,
    input  logic [PC_WIDTH-1:0] trap_vec,
    input  logic                ras_push,
    input  logic                ras_pop,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus,
    output logic                misalign,
    output logic [PC_WIDTH-1:0] ras_top,
    output logic                ras_empty,
    output logic                ras_full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_BR   = 2'b01;
    localparam logic [1:0] SRC_JALR = 2'b10;
    localparam logic [1:0] SRC_TRAP = 2'b11;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                misalign_q, misalign_d;

    // ras_ptr_q is the next write slot; the top entry sits one below it.
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0]    ras_cnt_q, ras_cnt_d;
    logic [PTR_W-1:0]    top_idx;
    logic                ras_we;
    logic [PTR_W-1:0]    ras_widx;

    logic [PC_WIDTH-1:0] seq_tgt, br_tgt, jr_sum, jr_tgt, sel_tgt;
    logic                sel_mis;
    logic                do_push, do_pop;

    assign seq_tgt = pc_q + PC_WIDTH'(PC_INC);
    assign br_tgt  = pc_q + imm_op;
    assign jr_sum  = rs1_val + imm_op;
    assign jr_tgt  = jr_sum & ~PC_WIDTH'(1);

    // Target select with misalignment redirect to the trap vector.
    always_comb begin
        sel_tgt = seq_tgt;
        sel_mis = 1'b0;
        unique case (pc_src)
            SRC_SEQ:  sel_tgt = seq_tgt;
            SRC_BR: begin
                if (br_tgt[1:0] != 2'b00) begin
                    sel_tgt = trap_vec;
                    sel_mis = 1'b1;
                end else begin
                    sel_tgt = br_tgt;
                end
            end
            SRC_JALR: begin
                if (jr_tgt[1]) begin
                    sel_tgt = trap_vec;
                    sel_mis = 1'b1;
                end else begin
                    sel_tgt = jr_tgt;
                end
            end
            SRC_TRAP: sel_tgt = trap_vec;
            default:  sel_tgt = seq_tgt;
        endcase
    end

    // Stall freezes the PC and the misalign pulse.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (!stall) begin
            pc_d       = sel_tgt;
            misalign_d = sel_mis;
        end
    end

    assign do_push = !stall && ras_push;
    assign do_pop  = !stall && ras_pop;
    assign top_idx = ras_ptr_q - PTR_W'(1);

    // RAS pointer/count update and entry write selection.
    always_comb begin
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ras_we    = 1'b0;
        ras_widx  = ras_ptr_q;
        if (do_push && do_pop && (ras_cnt_q != '0)) begin
            ras_we   = 1'b1;
            ras_widx = top_idx;
        end else if (do_push) begin
            ras_we    = 1'b1;
            ras_widx  = ras_ptr_q;
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (do_pop && (ras_cnt_q != '0)) begin
            ras_ptr_d = top_idx;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            ras_ptr_q  <= '0;
            ras_cnt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            ras_ptr_q  <= ras_ptr_d;
            ras_cnt_q  <= ras_cnt_d;
        end
    end

    // RAS storage; contents are meaningless while the count says empty.
    always_ff @(posedge clk) begin
        if (ras_we) begin
            ras_mem[ras_widx] <= pc_plus;
        end
    end

    assign pc        = pc_q;
    assign pc_plus   = seq_tgt;
    assign misalign  = misalign_q;
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

endmodule
